// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - Iterative unsigned multiply/divide unit with EX-stage stall sequencing
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             done_q;

    logic             accept;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ok;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;

    assign accept = (state == IDLE) && start && !flush;
    assign stall  = accept || (state == BUSY);
    assign busy   = (state != IDLE);
    assign done   = done_q && !flush;

    // hi/lo are shared: product halves for multiply, remainder/quotient for divide
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_shift = {hi, lo[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        if (op_q[1]) begin
            hi_next = div_ok ? div_diff : div_shift[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], div_ok};
        end else begin
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
            done_q <= 1'b0;
            result <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= op;
                        cnt  <= '0;
                        hi   <= '0;
                        opnd <= op[1] ? b : a;
                        lo   <= op[1] ? a : b;
                        if (op[1] && (b == '0)) begin
                            // Divide by zero: DIVU gives all ones, REMU gives the dividend
                            result <= op[0] ? a : {WIDTH{1'b1}};
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        hi  <= hi_next;
                        lo  <= lo_next;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            // op[0] picks the high half: MULHU and REMU
                            result <= op_q[0] ? hi_next : lo_next;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - Self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    localparam int W = 32;
    localparam int N = 80;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         flush;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] model_res = '0;

    logic         stall_tr [0:N-1];
    logic         done_tr  [0:N-1];
    logic         busy_tr  [0:N-1];
    logic [W-1:0] res_tr   [0:N-1];

    muldiv_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = (2*W)'(x) * (2*W)'(y);
        case (o)
            2'b00:   return p[W-1:0];
            2'b01:   return p[2*W-1:W];
            2'b10:   return (y == 0) ? {W{1'b1}} : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [W-1:0] y);
        return (o[1] && y == 0) ? 1 : W + 1;
    endfunction

    function automatic int first_done(input int n);
        for (int i = 0; i <= n; i++) if (done_tr[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_done(input int n);
        int k = 0;
        for (int i = 0; i <= n; i++) if (done_tr[i] === 1'b1) k++;
        return k;
    endfunction

    task automatic record(input int c);
        stall_tr[c] = stall;
        done_tr[c]  = done;
        busy_tr[c]  = busy;
        res_tr[c]   = result;
    endtask

    // Cycle 0 presents the request; operands are scrambled afterwards to prove capture
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int ncyc);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        #1 record(0);
        @(posedge clk);
        #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            record(c);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; flush = 1'b0; op = 2'b00; a = 32'd9; b = 32'd9;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: stall %b busy %b want 0 0", stall, busy); end
    endtask

    task automatic test_mul_timing;
        int bad = 0;
        issue(2'b00, 32'd7, 32'd6, 36);
        for (int c = 0; c <= 33; c++) if (stall_tr[c] !== (c < 33)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL mul_stall_pattern: %0d bad cycles want 0", bad); end
        checks++; if (first_done(36) != 33) begin errors++; $display("FAIL mul_done_cycle: got %0d want 33", first_done(36)); end
        checks++; if (count_done(36) != 1) begin errors++; $display("FAIL mul_done_count: got %0d want 1", count_done(36)); end
        checks++; if (res_tr[33] !== 32'd42) begin errors++; $display("FAIL mul_result: got %h want 2a", res_tr[33]); end
        checks++; if (busy_tr[0] !== 1'b0 || busy_tr[1] !== 1'b1 || busy_tr[33] !== 1'b1 || busy_tr[34] !== 1'b0)
            begin errors++; $display("FAIL mul_busy: c0 %b c1 %b c33 %b c34 %b want 0 1 1 0", busy_tr[0], busy_tr[1], busy_tr[33], busy_tr[34]); end
        checks++; if (res_tr[36] !== 32'd42) begin errors++; $display("FAIL mul_result_held: got %h want 2a", res_tr[36]); end
        model_res = 32'd42;
    endtask

    task automatic test_arith_table;
        logic [1:0]   t_op  [8] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b00};
        logic [W-1:0] t_a   [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd100, 32'h80000000, 32'd5, 32'd5, 32'd12345};
        logic [W-1:0] t_b   [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7, 32'd1, 32'd0, 32'd0, 32'd0};
        logic [W-1:0] t_exp [8] = '{32'hFFFFFFFE, 32'h00000001, 32'd14, 32'd2, 32'h80000000, 32'hFFFFFFFF, 32'd5, 32'd0};
        int           t_lat [8] = '{33, 33, 33, 33, 33, 1, 1, 33};
        for (int i = 0; i < 8; i++) begin
            issue(t_op[i], t_a[i], t_b[i], 36);
            checks++; if (first_done(36) != t_lat[i]) begin errors++; $display("FAIL table%0d_latency: got %0d want %0d", i, first_done(36), t_lat[i]); end
            checks++; if (count_done(36) != 1) begin errors++; $display("FAIL table%0d_done_count: got %0d want 1", i, count_done(36)); end
            checks++; if (res_tr[t_lat[i]] !== t_exp[i]) begin errors++; $display("FAIL table%0d_result: got %h want %h", i, res_tr[t_lat[i]], t_exp[i]); end
            model_res = t_exp[i];
        end
    endtask

    task automatic test_div_zero_timing;
        issue(2'b10, 32'd5, 32'd0, 4);
        checks++; if (stall_tr[0] !== 1'b1 || stall_tr[1] !== 1'b0 || stall_tr[2] !== 1'b0)
            begin errors++; $display("FAIL dz_stall: c0 %b c1 %b c2 %b want 1 0 0", stall_tr[0], stall_tr[1], stall_tr[2]); end
        checks++; if (done_tr[1] !== 1'b1 || done_tr[2] !== 1'b0) begin errors++; $display("FAIL dz_done: c1 %b c2 %b want 1 0", done_tr[1], done_tr[2]); end
        checks++; if (busy_tr[1] !== 1'b1 || busy_tr[2] !== 1'b0) begin errors++; $display("FAIL dz_busy: c1 %b c2 %b want 1 0", busy_tr[1], busy_tr[2]); end
        checks++; if (res_tr[1] !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_result: got %h want ffffffff", res_tr[1]); end
        model_res = 32'hFFFFFFFF;
    endtask

    task automatic test_random;
        logic [1:0]   o;
        logic [W-1:0] x, y, e;
        int           lat;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = '0;
                1:       y = W'($urandom_range(1, 255));
                default: y = $urandom;
            endcase
            e = ref_result(o, x, y);
            lat = ref_latency(o, y);
            issue(o, x, y, 35);
            checks++; if (first_done(35) != lat) begin errors++; $display("FAIL rand%0d_latency: op %0d got %0d want %0d", i, o, first_done(35), lat); end
            checks++; if (res_tr[lat] !== e) begin errors++; $display("FAIL rand%0d_result: op %0d a %h b %h got %h want %h", i, o, x, y, res_tr[lat], e); end
            model_res = e;
        end
    endtask

    task automatic test_flush;
        int ndone = 0;
        logic [W-1:0] prior = model_res;
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            flush = (c == 10);
            @(negedge clk);
            if (done === 1'b1) ndone++;
            if (c == 10) begin
                checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_stall_c10: got %b want 1", stall); end
            end
            if (c == 11) begin
                checks++; if (busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL flush_idle_c11: busy %b stall %b want 0 0", busy, stall); end
            end
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        checks++; if (ndone != 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses want 0", ndone); end
        checks++; if (result !== prior) begin errors++; $display("FAIL flush_result_kept: got %h want %h", result, prior); end
    endtask

    task automatic test_reset_mid;
        int ndone = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            rst = (c == 20);
            flush = (c == 20);
            @(negedge clk);
            if (done === 1'b1) ndone++;
            if (c == 21) begin
                checks++; if (result !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_c21: result %h busy %b want 0 0", result, busy); end
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        flush = 1'b0;
        checks++; if (ndone != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", ndone); end
        checks++; if (result !== '0) begin errors++; $display("FAIL rstmid_result: got %h want 0", result); end
        model_res = '0;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3;
        #1 record(0);
        @(posedge clk);
        #1;
        for (int c = 1; c <= 70; c++) begin
            if (c == 5 || c == 33 || c == 34) begin
                start = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1;
            end else begin
                start = 1'b0; op = 2'b10; a = $urandom; b = $urandom;
            end
            @(negedge clk);
            record(c);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checks++; if (first_done(70) != 33) begin errors++; $display("FAIL b2b_first_done: got %0d want 33", first_done(70)); end
        checks++; if (res_tr[33] !== 32'd3) begin errors++; $display("FAIL b2b_div_result: got %h want 3", res_tr[33]); end
        checks++; if (stall_tr[33] !== 1'b0 || stall_tr[34] !== 1'b1) begin errors++; $display("FAIL b2b_stall: c33 %b c34 %b want 0 1", stall_tr[33], stall_tr[34]); end
        checks++; if (done_tr[67] !== 1'b1 || count_done(70) != 2) begin errors++; $display("FAIL b2b_second_done: c67 %b count %0d want 1 2", done_tr[67], count_done(70)); end
        checks++; if (res_tr[67] !== 32'd1) begin errors++; $display("FAIL b2b_mul_result: got %h want 1", res_tr[67]); end
        model_res = 32'd1;
    endtask

    initial begin
        test_reset;
        test_mul_timing;
        test_arith_table;
        test_div_zero_timing;
        test_random;
        test_flush;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
